sample_tap_buffer: RTL and testbench

SAMPLE_TAP_BUFFER -- requirements
Module: sample_tap_buffer

---
 rtl/sample_tap_buffer.sv | 144 ++++++++++++++
 tb/tb_sample_tap_buffer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sample_tap_buffer.sv
// sample_tap_buffer: 64-deep circular history of Q15 samples. Each accepted
// sample starts a 64-cycle frame that presents every stored sample on x,
// newest first, to a FIR multiply-accumulate stage. A sample offered while a
// frame is still running is dropped and the sticky overrun flag is set.
//
// Optional feature: define SAMPLE_TAP_BUFFER_ZERO_FILL_EN to add a saturating
// fill counter so that taps not yet written since reset read as zero.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for din_valid; ready high, tap_valid low, x = 0
// STREAM | presenting taps k = 0..63, one per cycle; incoming samples dropped

module sample_tap_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] din,
    input  logic        din_valid,
    output logic        ready,
    output logic [15:0] x,
    output logic [5:0]  tap_idx,
    output logic        tap_valid,
    output logic        frame_start,
    output logic        frame_done,
    input  logic        overrun_clr,
    output logic        overrun
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t      state;
    logic [15:0] mem [64];
    logic [5:0]  wp;
    logic [5:0]  k;
    logic [5:0]  k_next;
    logic [5:0]  rd_addr;
    logic        accept;
    logic        drop;
    logic        tap_live;

    assign ready   = (state == IDLE);
    assign accept  = (state == IDLE) && din_valid;
    assign drop    = (state == STREAM) && din_valid;
    assign k_next  = k + 6'd1;
    // Modulo-64 wrap of the unsigned subtraction walks back through history.
    assign rd_addr = wp - k_next;
    assign tap_idx = k;

`ifdef SAMPLE_TAP_BUFFER_ZERO_FILL_EN
    logic [6:0] fill;

    // Count accepted samples since reset, saturating once the buffer is full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill <= 7'd0;
        end else if (accept && (fill != 7'd64)) begin
            fill <= fill + 7'd1;
        end
    end

    // Taps at or beyond the fill level have not been written since reset.
    assign tap_live = ({1'b0, k_next} < fill);
`else
    assign tap_live = 1'b1;
`endif

    // History storage is deliberately not reset; only the pointer is.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wp] <= din;
        end
    end

    // Frame sequencer with registered tap outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wp          <= 6'd0;
            k           <= 6'd0;
            x           <= 16'd0;
            tap_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    frame_done <= 1'b0;
                    if (din_valid) begin
                        // Tap 0 is taken straight from din so the newest
                        // sample is shown even though mem is written this edge.
                        state       <= STREAM;
                        k           <= 6'd0;
                        x           <= din;
                        tap_valid   <= 1'b1;
                        frame_start <= 1'b1;
                    end else begin
                        x           <= 16'd0;
                        tap_valid   <= 1'b0;
                        frame_start <= 1'b0;
                    end
                end
                STREAM: begin
                    frame_start <= 1'b0;
                    if (k == 6'd63) begin
                        state      <= IDLE;
                        wp         <= wp + 6'd1;
                        k          <= 6'd0;
                        x          <= 16'd0;
                        tap_valid  <= 1'b0;
                        frame_done <= 1'b0;
                    end else begin
                        k          <= k_next;
                        x          <= tap_live ? mem[rd_addr] : 16'd0;
                        tap_valid  <= 1'b1;
                        frame_done <= (k_next == 6'd63);
                    end
                end
                default: begin
                    state       <= IDLE;
                    k           <= 6'd0;
                    x           <= 16'd0;
                    tap_valid   <= 1'b0;
                    frame_start <= 1'b0;
                    frame_done  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky drop flag; a drop wins over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sample_tap_buffer.sv
// Bench for sample_tap_buffer: directed steps drive samples, a history model
// pushes the expected 64 taps per accepted sample onto a queue, and a
// negedge monitor pops and compares them.
module tb_sample_tap_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] din = 16'd0;
    logic        din_valid = 1'b0;
    logic        ready;
    logic [15:0] x;
    logic [5:0]  tap_idx;
    logic        tap_valid;
    logic        frame_start;
    logic        frame_done;
    logic        overrun_clr = 1'b0;
    logic        overrun;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [15:0] x;
        logic [5:0]  idx;
        logic        start;
        logic        done;
        logic        care;
    } tap_t;

    tap_t        exp_q[$];
    tap_t        e;
    logic [15:0] m_mem [64];
    logic        m_wr  [64];
    logic [5:0]  m_wp = 6'd0;
    int          m_fill = 0;

    sample_tap_buffer dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .din_valid   (din_valid),
        .ready       (ready),
        .x           (x),
        .tap_idx     (tap_idx),
        .tap_valid   (tap_valid),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .overrun_clr (overrun_clr),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_wp   = 6'd0;
        m_fill = 0;
        exp_q.delete();
    endtask

    task automatic push_frame(input logic [15:0] d);
        tap_t       t;
        logic [5:0] a;
        m_mem[m_wp] = d;
        m_wr[m_wp]  = 1'b1;
        if (m_fill < 64) m_fill++;
        for (int kk = 0; kk < 64; kk++) begin
            a       = m_wp - 6'(kk);
            t.idx   = 6'(kk);
            t.start = (kk == 0);
            t.done  = (kk == 63);
`ifdef SAMPLE_TAP_BUFFER_ZERO_FILL_EN
            t.care  = 1'b1;
            t.x     = (kk < m_fill) ? m_mem[a] : 16'd0;
`else
            t.care  = m_wr[a];
            t.x     = m_mem[a];
`endif
            exp_q.push_back(t);
        end
        m_wp = m_wp + 6'd1;
    endtask

    task automatic send(input logic [15:0] d);
        din       = d;
        din_valid = 1'b1;
        push_frame(d);
        tick();
        din_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
        end
        check("wait_ready", ready, 1);
    endtask

    task automatic wait_tap(input logic [5:0] idx);
        int n = 0;
        while (!(tap_valid && tap_idx == idx) && n < 200) begin
            tick();
            n++;
        end
        check("wait_tap", tap_idx, idx);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_x"}, x, 0);
        check({tag, "_tap_idx"}, tap_idx, 0);
        check({tag, "_tap_valid"}, tap_valid, 0);
        check({tag, "_frame_start"}, frame_start, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_ready"}, ready, 1);
    endtask

    // Scoreboard monitor: compare every cycle away from the rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (tap_valid) begin
                check("ready_in_stream", ready, 0);
                if (exp_q.size() == 0) begin
                    check("tap_without_expectation", tap_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.care) check("tap_x", x, e.x);
                    check("tap_idx", tap_idx, e.idx);
                    check("frame_start", frame_start, e.start);
                    check("frame_done", frame_done, e.done);
                end
            end else begin
                check("idle_x", x, 0);
                check("idle_frame_start", frame_start, 0);
                check("idle_frame_done", frame_done, 0);
            end
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) m_wr[i] = 1'b0;

        // Asynchronous reset, checked before any clock edge.
        #2 reset = 1'b1;
        #1 check_outputs_zero("reset");
        tick();
        tick();
        reset = 1'b0;
        model_reset();

        // First frame after reset.
        send(16'h1234);
        wait_ready();

        // Ordering and wrap: samples 1..70, 65-cycle spacing from wp = 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        for (int s = 1; s <= 70; s++) begin
            send(16'(s));
            wait_ready();
        end
        check("overrun_before_drop", overrun, 0);

        // Overrun: drop at k=10 and on the frame_done cycle.
        send(16'h4A4A);
        wait_tap(6'd10);
        din       = 16'hDEAD;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        check("overrun_set", overrun, 1);
        wait_tap(6'd63);
        check("frame_done_seen", frame_done, 1);
        din         = 16'hBEEF;
        din_valid   = 1'b1;
        overrun_clr = 1'b1;
        tick();
        din_valid   = 1'b0;
        overrun_clr = 1'b0;
        check("overrun_set_beats_clr", overrun, 1);
        check("ready_after_done_drop", ready, 1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("overrun_cleared", overrun, 0);
        send(16'h5B5B);
        wait_ready();

        // Mid-frame reset at k=30.
        send(16'h6C6C);
        wait_tap(6'd30);
        reset = 1'b1;
        #1 check_outputs_zero("midreset");
        model_reset();
        tick();
        tick();
        reset = 1'b0;
        send(16'h7D7D);
        wait_ready();

        // Back-to-back: din_valid held high for three frame periods.
        din_valid = 1'b1;
        for (int i = 0; i < 195; i++) begin
            din = 16'h8000 + 16'(i);
            check("b2b_ready", ready, ((i % 65) == 0));
            if ((i % 65) == 0) push_frame(din);
            tick();
        end
        din_valid = 1'b0;
        check("b2b_overrun", overrun, 1);
        wait_ready();
        tick();
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
